demux_1x3_reg: RTL and testbench
================================

# demux_1x3_reg

Registered 1-to-3 demultiplexer: routes each beat on a single valid/ready input stream to one of three output lanes chosen by a 2-bit selector, holding the beat in a one-entry lane register until that lane's consumer accepts it. It is the distribution counterpart of the 3-to-1 select muxes in the datapath. It sits where one producer (e.g. a write-back or control source) must steer data into one of three destinations that can stall independently. Illegal selector code 2'b11 is consumed, dropped and counted.

## Interface
Parameters:
- WIDTH, 1, data width of the input beat and of each lane.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_sel  in  2  destination lane: 2'b00 lane 0, 2'b01 lane 1, 2'b10 lane 2, 2'b11 illegal.
- in_data  in  WIDTH  input beat payload.
- in_ready  out  1  input beat accepted this cycle when high with in_valid.
- out_valid  out  3  per-lane beat present; bit i is lane i.
- out_data0, out_data1, out_data2  out  WIDTH  lane payloads.
- out_ready  in  3  per-lane consumer ready.
- err  out  1  one-cycle pulse: an illegal-select beat was dropped in the previous cycle.
- drop_cnt  out  CNT_W  count of dropped beats, saturating.

## Operation
- Each lane holds one register entry: full flag (drives out_valid[i]) and data register.
- Lane i drains when out_valid[i] && out_ready[i].
- Lane i can take a new beat when it is empty or draining this cycle, so steady-state throughput is one beat per cycle per lane.
- in_ready is combinational: 1 when in_sel == 2'b11; otherwise the take condition of lane in_sel. in_ready depends on in_sel and out_ready only, never on in_valid.
- Accept (in_valid && in_ready) with a legal sel: lane in_sel loads in_data and stays or becomes full. Other lanes are unaffected, apart from their own drains.
- Accept with sel 2'b11: payload discarded, err = 1 next cycle, drop_cnt increments next cycle. drop_cnt holds at all-ones once it saturates. No lane changes.
- Simultaneous drain and load on the same lane: out_valid stays 1 and data is replaced by the new beat.
- Drain with no load: out_valid goes to 0. The data register holds its last value, which is don't-care.
- out_data of a full lane is stable while out_ready is low.
- Reset (asynchronous assert, any time): out_valid = 3'b000, out_data* = 0, err = 0, drop_cnt = 0. In-flight entries are lost. Deassertion is used as-is; it is synchronized upstream.

## Timing
- Latency input to lane output: 1 cycle. A beat accepted at edge N is visible on out_valid/out_data at edge N.
- No combinational path from in_data to out_data*.
- Combinational paths: out_ready → in_ready and in_sel → in_ready only.
- err and drop_cnt update at the same edge that accepts the illegal beat.
- Lanes are independent: a stalled lane never blocks beats addressed to other lanes.
- Beat ordering is preserved per lane. There is no ordering guarantee across lanes.

## Structure
- Shared package/include holds the select-code constants SEL_L0 = 2'b00, SEL_L1 = 2'b01, SEL_L2 = 2'b10, SEL_ILL = 2'b11 and the lane count 3. The datapath muxes use the same constants.
- One sub-module, demux_lane: parameter WIDTH; ports clk, reset_n, load, load_data, out_ready, out_valid, out_data, can_load. The top instantiates it three times and adds the select decode, in_ready generation and the drop/err logic.

## Test plan
- Reset mid-traffic: fill lanes 0 and 2, assert reset_n = 0 between edges → out_valid = 3'b000, drop_cnt = 0 immediately without a clock edge.
- Routing: WIDTH = 8, out_ready = 3'b111; send 8'hA1/sel 0, 8'hB2/sel 1, 8'hC3/sel 2 on consecutive cycles → each appears one cycle later, only on its lane, with out_valid one-hot.
- Backpressure: out_ready[1] = 0, send 8'h11 then 8'h22 to lane 1 → lane 1 holds 8'h11 and in_ready = 0 for sel 1. A beat to lane 0 is still accepted. Raising out_ready[1] accepts 8'h22 in the same cycle 8'h11 drains.
- Illegal select: send 3 beats with sel 2'b11 → in_ready = 1, err pulses 3 times, drop_cnt = 3, out_valid unchanged.
- Saturation: CNT_W = 2, send 5 illegal beats → drop_cnt stops at 3 and err still pulses every time.
- Full throughput: lane 2 with out_ready held at 1, 16 back-to-back beats → 16 outputs in order, one per cycle, with no in_ready bubble.

Source files
------------

// File: rtl/demux_1x3_reg_pkg.sv
// rtl/demux_1x3_reg_pkg.sv - select codes and lane count shared by the demux and the datapath muxes
package demux_1x3_reg_pkg;
  localparam int NUM_LANES = 3;

  localparam logic [1:0] SEL_L0  = 2'b00;
  localparam logic [1:0] SEL_L1  = 2'b01;
  localparam logic [1:0] SEL_L2  = 2'b10;
  localparam logic [1:0] SEL_ILL = 2'b11;
endpackage

// File: rtl/demux_lane.sv
// rtl/demux_lane.sv - one-entry output register for a single demux lane
module demux_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);
  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // A draining entry frees the slot in the same cycle, giving one beat per cycle.
  assign can_load  = !r_full || out_ready;
  assign out_valid = r_full;
  assign out_data  = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (load) begin
        r_full <= 1'b1;
        r_data <= load_data;
      end else if (out_ready) begin
        r_full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/demux_1x3_reg.sv
// rtl/demux_1x3_reg.sv - registered 1-to-3 stream demux with illegal-select drop counter
import demux_1x3_reg_pkg::*;

module demux_1x3_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [1:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic [NUM_LANES-1:0] out_valid,
  output logic [WIDTH-1:0]     out_data0,
  output logic [WIDTH-1:0]     out_data1,
  output logic [WIDTH-1:0]     out_data2,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic                 err,
  output logic [CNT_W-1:0]     drop_cnt
);
  logic [NUM_LANES-1:0] w_can_load;
  logic [NUM_LANES-1:0] w_load;
  logic [WIDTH-1:0]     w_lane_data [NUM_LANES];
  logic                 w_accept;
  logic                 w_drop;
  logic                 r_err;
  logic [CNT_W-1:0]     r_drop_cnt;

  // Illegal beats are always consumed so a bad selector can never wedge the producer.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      SEL_L0:  in_ready = w_can_load[0];
      SEL_L1:  in_ready = w_can_load[1];
      SEL_L2:  in_ready = w_can_load[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && (in_sel == SEL_ILL);

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_load[g] = w_accept && (in_sel == 2'(g));

      demux_lane #(.WIDTH(WIDTH)) u_lane (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_load[g]),
        .load_data (in_data),
        .out_ready (out_ready[g]),
        .out_valid (out_valid[g]),
        .out_data  (w_lane_data[g]),
        .can_load  (w_can_load[g])
      );
    end
  endgenerate

  assign out_data0 = w_lane_data[0];
  assign out_data1 = w_lane_data[1];
  assign out_data2 = w_lane_data[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign err      = r_err;
  assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_demux_1x3_reg.sv
// tb/tb_demux_1x3_reg.sv - scoreboard bench for demux_1x3_reg
module tb_demux_1x3_reg;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [1:0] in_sel;
  logic [7:0] in_data;
  logic       in_ready;
  logic [2:0] out_valid;
  logic [7:0] out_data0, out_data1, out_data2;
  logic [2:0] out_ready;
  logic       err;
  logic [7:0] drop_cnt;

  logic       in_ready_s;
  logic [2:0] out_valid_s;
  logic [7:0] out_data0_s, out_data1_s, out_data2_s;
  logic       err_s;
  logic [1:0] drop_cnt_s;

  int tests = 0;
  int failed = 0;

  logic [7:0] q0[$], q1[$], q2[$];
  logic [7:0] err_q[$];
  logic [1:0] sat_q[$];
  logic [7:0] exp_drop;
  logic [1:0] exp_sat;

  always #5 clk = ~clk;

  demux_1x3_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_ready(out_ready), .err(err), .drop_cnt(drop_cnt)
  );

  demux_1x3_reg #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
    .in_ready(in_ready_s), .out_valid(out_valid_s), .out_data0(out_data0_s), .out_data1(out_data1_s),
    .out_data2(out_data2_s), .out_ready(out_ready), .err(err_s), .drop_cnt(drop_cnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    failed++;
    $display("FAIL %s: output seen with empty scoreboard", name);
  endtask

  // Monitor: a beat counts as delivered when valid and ready are both high before the edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid[0] && out_ready[0]) begin
        if (q0.size() == 0) unexpected("lane0_extra"); else check("lane0_data", out_data0, q0.pop_front());
      end
      if (out_valid[1] && out_ready[1]) begin
        if (q1.size() == 0) unexpected("lane1_extra"); else check("lane1_data", out_data1, q1.pop_front());
      end
      if (out_valid[2] && out_ready[2]) begin
        if (q2.size() == 0) unexpected("lane2_extra"); else check("lane2_data", out_data2, q2.pop_front());
      end
      if (err) begin
        if (err_q.size() == 0) unexpected("err_extra"); else check("drop_cnt", drop_cnt, err_q.pop_front());
      end
      if (err_s) begin
        if (sat_q.size() == 0) unexpected("err_sat_extra"); else check("drop_cnt_sat", drop_cnt_s, sat_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] s, output int waits);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      case (s)
        2'd0: q0.push_back(d);
        2'd1: q1.push_back(d);
        2'd2: q2.push_back(d);
        default: begin
          exp_drop = exp_drop + 8'd1;
          err_q.push_back(exp_drop);
          if (exp_sat != 2'd3) exp_sat = exp_sat + 2'd1;
          sat_q.push_back(exp_sat);
        end
      endcase
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] rdata [3];
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'b00;
    in_data   = 8'h00;
    out_ready = 3'b111;
    exp_drop  = 8'd0;
    exp_sat   = 2'd0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Routing: each beat appears on its own lane only, one cycle after acceptance.
    rdata[0] = 8'hA1; rdata[1] = 8'hB2; rdata[2] = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      send(rdata[k], 2'(k), w);
      check("route_no_stall", 32'(w), 32'd0);
      check("route_onehot", 32'(out_valid), 32'(3'b001 << k));
    end
    check("route_data2", 32'(out_data2), 32'hC3);

    // Backpressure on lane 1.
    @(posedge clk); #1;
    out_ready = 3'b101;
    send(8'h11, 2'd1, w);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h22;
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_hold_data", 32'(out_data1), 32'h11);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_hold_valid", 32'(out_valid[1]), 32'd1);
    send(8'h33, 2'd0, w);
    check("bp_other_lane", 32'(w), 32'd0);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h22;
    out_ready = 3'b111;
    send(8'h22, 2'd1, w);
    check("bp_release_same_cycle", 32'(w), 32'd0);
    check("bp_new_data", 32'(out_data1), 32'h22);
    check("bp_valid_kept", 32'(out_valid[1]), 32'd1);

    // Illegal selects with a stalled beat parked on lane 0.
    @(posedge clk); #1;
    out_ready = 3'b110;
    send(8'h55, 2'd0, w);
    for (int k = 0; k < 3; k++) begin
      send(8'hEE, 2'd3, w);
      check("ill_ready", 32'(w), 32'd0);
    end
    check("ill_drop_cnt3", 32'(drop_cnt), 32'd3);
    check("ill_valid_unchanged", 32'(out_valid), 32'b001);
    check("ill_data_unchanged", 32'(out_data0), 32'h55);
    for (int k = 0; k < 2; k++) send(8'hEF, 2'd3, w);
    check("ill_drop_cnt5", 32'(drop_cnt), 32'd5);
    check("sat_drop_cnt", 32'(drop_cnt_s), 32'd3);

    // Full throughput on lane 2.
    @(posedge clk); #1;
    out_ready = 3'b111;
    for (int k = 0; k < 16; k++) begin
      send(8'h40 + 8'(k), 2'd2, w);
      check("thru_bubble", 32'(w), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with lanes 0 and 2 occupied.
    out_ready = 3'b000;
    send(8'h01, 2'd0, w);
    send(8'h02, 2'd2, w);
    check("mid_valid_before", 32'(out_valid), 32'b101);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_drop_sat", 32'(drop_cnt_s), 32'd0);
    check("mid_rst_data0", 32'(out_data0), 32'd0);
    q0.delete(); q1.delete(); q2.delete(); err_q.delete(); sat_q.delete();
    exp_drop = 8'd0;
    exp_sat  = 2'd0;
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 3'b111;
    repeat (3) @(posedge clk);
    #1;

    check("sb_lane0_empty", 32'(q0.size()), 32'd0);
    check("sb_lane1_empty", 32'(q1.size()), 32'd0);
    check("sb_lane2_empty", 32'(q2.size()), 32'd0);
    check("sb_err_empty", 32'(err_q.size() + sat_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
